// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the dual-clock FIFO: drains a programmed burst through
// ren/empty and delivers it on a valid/ready stream via a 2-entry skid buffer.
module fifo_read_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_ren,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  rd_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_r;
   state_t                state_next_s;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  issued_r;
   logic [LEN_WIDTH-1:0]  rd_count_r;
   logic [LEN_WIDTH-1:0]  rd_count_next_s;
   logic                  inflight_r;
   logic                  done_r;
   logic [DATA_WIDTH-1:0] buf0_r;
   logic [DATA_WIDTH-1:0] buf1_r;
   logic [1:0]            occ_r;
   logic                  pop_s;
   logic                  ren_s;
   logic                  accept_s;
   logic                  zero_start_s;
   logic                  finish_s;
   logic [2:0]            pending_s;

   // Stream handshake and delivered-count lookahead
   always_comb begin
      pop_s = (occ_r != 2'd0) && m_ready;
      if (pop_s) begin
         rd_count_next_s = rd_count_r + LEN_ONE;
      end else begin
         rd_count_next_s = rd_count_r;
      end
   end

   // Issue a read only if the word can land in the buffer next cycle
   always_comb begin
      pending_s = {1'b0, occ_r} + {2'b00, inflight_r};
      if ((state_r == RUN) && !fifo_empty && (issued_r < len_r) &&
          (pending_s <= (3'd1 + {2'b00, pop_s}))) begin
         ren_s = 1'b1;
      end else begin
         ren_s = 1'b0;
      end
   end

   // Next-state decode; completion is seen on the cycle of the last pop
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      zero_start_s = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (burst_len != LEN_ZERO) begin
                  accept_s     = 1'b1;
                  state_next_s = RUN;
               end else begin
                  zero_start_s = 1'b1;
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (rd_count_next_s == len_r) begin
               finish_s     = 1'b1;
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Burst length, counters, in-flight flag and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r      <= LEN_ZERO;
         issued_r   <= LEN_ZERO;
         rd_count_r <= LEN_ZERO;
         inflight_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         inflight_r <= ren_s;
         done_r     <= finish_s | zero_start_s;
         if (accept_s) begin
            len_r      <= burst_len;
            issued_r   <= LEN_ZERO;
            rd_count_r <= LEN_ZERO;
         end else if (zero_start_s) begin
            issued_r   <= LEN_ZERO;
            rd_count_r <= LEN_ZERO;
         end else begin
            if (ren_s) begin
               issued_r <= issued_r + LEN_ONE;
            end
            rd_count_r <= rd_count_next_s;
         end
      end
   end

   // Two-entry output buffer: buf0 is the head, the returning word goes to the tail
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf0_r <= {DATA_WIDTH{1'b0}};
         buf1_r <= {DATA_WIDTH{1'b0}};
         occ_r  <= 2'd0;
      end else begin
         case ({inflight_r, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  buf0_r <= fifo_dout;
               end else begin
                  buf1_r <= fifo_dout;
               end
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               buf0_r <= buf1_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  buf0_r <= fifo_dout;
               end else begin
                  buf0_r <= buf1_r;
                  buf1_r <= fifo_dout;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

   assign fifo_ren = ren_s;
   assign m_data   = buf0_r;
   assign m_valid  = (occ_r != 2'd0);
   assign busy     = (state_r != IDLE);
   assign done     = done_r;
   assign rd_count = rd_count_r;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a queue-based FIFO model feeds the DUT and
// the expected word order is held in a second queue popped on every stream transfer.
module tb_fifo_read_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_ren;
   logic        start;
   logic [9:0]  burst_len;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic [9:0]  rd_count;

   logic [15:0] fq[$];
   logic [15:0] exp_q[$];

   int vec_cnt, err_cnt, cyc;
   int ren_cnt, pop_cnt, done_cnt;
   int first_ren_cyc, last_ren_cyc, first_valid_cyc, last_pop_cyc, done_cyc, start_cyc;
   logic        prev_v, prev_r, rand_ready;
   logic [15:0] prev_d;

   fifo_read_ctrl #(.DATA_WIDTH(16), .LEN_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_ren(fifo_ren), .start(start), .burst_len(burst_len), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .rd_count(rd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      vec_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic fifo_push(input logic [15:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic fifo_flush();
      fq.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic clear_stats();
      ren_cnt = 0; pop_cnt = 0; done_cnt = 0;
      first_ren_cyc = -1; last_ren_cyc = -1; first_valid_cyc = -1;
      last_pop_cyc = -1; done_cyc = -1;
   endtask

   // One clock: sample at negedge, then the FIFO model answers reads after posedge
   task automatic cycle();
      logic ren_now;
      logic pop;
      @(negedge clk);
      pop = m_valid && m_ready;
      if (fifo_ren) check_eq("ren_nonempty", 32'(fifo_empty), 32'd0);
      if (prev_v && !prev_r) check_eq("hold_stable", 32'({m_valid, m_data}), 32'({1'b1, prev_d}));
      if (pop) begin
         if (exp_q.size() == 0) check_eq("extra_word", 32'(exp_q.size()), 32'd1);
         else check_eq("data", 32'(m_data), 32'(exp_q.pop_front()));
         pop_cnt++;
         last_pop_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (fifo_ren) begin
         ren_cnt++;
         if (first_ren_cyc < 0) first_ren_cyc = cyc;
         last_ren_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
      ren_now = fifo_ren;
      @(posedge clk);
      cyc++;
      #1;
      if (ren_now && fq.size() > 0) fifo_dout = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_burst(input logic [9:0] len);
      start = 1'b1;
      burst_len = len;
      start_cyc = cyc;
      cycle();
      start = 1'b0;
      burst_len = 10'd0;
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget && done_cnt == 0; n++) cycle();
      cycle();
      cycle();
      check_eq("done_once", 32'(done_cnt), 32'd1);
      check_eq("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      vec_cnt = 0; err_cnt = 0; cyc = 0;
      rst = 1'b0; start = 1'b0; burst_len = 10'd0; m_ready = 1'b1;
      fifo_dout = 16'd0; fifo_empty = 1'b1; rand_ready = 1'b0;
      prev_v = 1'b0; prev_r = 1'b0; prev_d = 16'd0;
      clear_stats();

      // Reset values
      #1 rst = 1'b1;
      #2 check_eq("reset_outs", 32'({fifo_ren, m_valid, busy, done, rd_count, m_data}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic burst of 4
      for (int i = 1; i <= 4; i++) fifo_push(16'(i));
      clear_stats();
      start_burst(10'd4);
      wait_done(40);
      check_eq("basic_ren_cnt", 32'(ren_cnt), 32'd4);
      check_eq("basic_ren_consec", 32'(last_ren_cyc - first_ren_cyc), 32'd3);
      check_eq("basic_first_ren", 32'(first_ren_cyc - start_cyc), 32'd1);
      check_eq("basic_latency", 32'(first_valid_cyc - first_ren_cyc), 32'd2);
      check_eq("basic_pops", 32'(pop_cnt), 32'd4);
      check_eq("basic_pop_span", 32'(last_pop_cyc - first_valid_cyc), 32'd3);
      check_eq("basic_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);
      check_eq("basic_rd_count", 32'(rd_count), 32'd4);

      // Backpressure: 8 words, consumer stalled
      for (int i = 0; i < 8; i++) fifo_push(16'h0A00 + 16'(i));
      m_ready = 1'b0;
      clear_stats();
      start_burst(10'd8);
      repeat (10) cycle();
      check_eq("bp_ren_cnt", 32'(ren_cnt), 32'd2);
      check_eq("bp_valid", 32'(m_valid), 32'd1);
      check_eq("bp_head", 32'(m_data), 32'(exp_q[0]));
      check_eq("bp_busy", 32'(busy), 32'd1);
      m_ready = 1'b1;
      wait_done(60);
      check_eq("bp_pops", 32'(pop_cnt), 32'd8);
      check_eq("bp_ren_total", 32'(ren_cnt), 32'd8);
      check_eq("bp_rd_count", 32'(rd_count), 32'd8);

      // Empty stall mid-burst
      for (int i = 0; i < 3; i++) fifo_push(16'h0B00 + 16'(i));
      clear_stats();
      start_burst(10'd5);
      repeat (10) cycle();
      check_eq("stall_ren_cnt", 32'(ren_cnt), 32'd3);
      check_eq("stall_busy", 32'(busy), 32'd1);
      check_eq("stall_ren_low", 32'(fifo_ren), 32'd0);
      check_eq("stall_rd_count", 32'(rd_count), 32'd3);
      fifo_push(16'h0B03);
      fifo_push(16'h0B04);
      wait_done(40);
      check_eq("stall_pops", 32'(pop_cnt), 32'd5);
      check_eq("stall_rd_final", 32'(rd_count), 32'd5);

      // Zero-length start
      clear_stats();
      start_burst(10'd0);
      wait_done(5);
      check_eq("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);
      check_eq("zero_ren_cnt", 32'(ren_cnt), 32'd0);
      check_eq("zero_rd_count", 32'(rd_count), 32'd0);

      // Start while busy is ignored
      for (int i = 0; i < 10; i++) fifo_push(16'h0C00 + 16'(i));
      clear_stats();
      start_burst(10'd10);
      repeat (4) cycle();
      start_burst(10'd3);
      wait_done(60);
      check_eq("busy_start_pops", 32'(pop_cnt), 32'd10);
      check_eq("busy_start_rd", 32'(rd_count), 32'd10);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 8; i++) fifo_push(16'h0D00 + 16'(i));
      clear_stats();
      start_burst(10'd8);
      for (int n = 0; n < 40 && pop_cnt < 3; n++) cycle();
      check_eq("rst_pre_pops", 32'(pop_cnt), 32'd3);
      #2 rst = 1'b1;
      #1 check_eq("rst_mid_outs", 32'({fifo_ren, m_valid, busy, done, rd_count, m_data}), 32'd0);
      prev_v = 1'b0;
      cycle();
      rst = 1'b0;
      exp_q = fq;
      prev_v = 1'b0;
      clear_stats();
      start_burst(10'd2);
      wait_done(40);
      check_eq("rst_post_pops", 32'(pop_cnt), 32'd2);
      check_eq("rst_post_rd", 32'(rd_count), 32'd2);
      fifo_flush();

      // Full-depth drain with random backpressure
      for (int i = 0; i < 512; i++) fifo_push(16'($urandom_range(0, 65535)));
      rand_ready = 1'b1;
      clear_stats();
      start_burst(10'd512);
      wait_done(6000);
      rand_ready = 1'b0;
      m_ready = 1'b1;
      check_eq("full_pops", 32'(pop_cnt), 32'd512);
      check_eq("full_rd_count", 32'(rd_count), 32'd512);
      check_eq("full_fifo_empty", 32'(fifo_empty), 32'd1);
      check_eq("full_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
